// File: rtl/alu_frame_interface.sv
// alu_frame_interface: assembles framed RX bytes into ALU operands and opcode,
// runs the ALU under a timeout and streams the result and flags into TX.
module alu_frame_interface #(
    parameter int BYTE_WIDTH     = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int OPCODE_WIDTH   = 6,
    parameter int SEND_FLAGS     = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [BYTE_WIDTH-1:0]   i_rx_data,
    input  logic                    i_rxff_empty,
    output logic                    o_rxff_read,
    output logic [DATA_WIDTH-1:0]   o_operandA,
    output logic [DATA_WIDTH-1:0]   o_operandB,
    output logic [OPCODE_WIDTH-1:0] o_opcode,
    output logic                    o_alu_start,
    input  logic [DATA_WIDTH-1:0]   i_alu_result,
    input  logic [4:0]              i_alu_flags,
    input  logic                    i_alu_done,
    output logic [BYTE_WIDTH-1:0]   o_tx_data,
    output logic                    o_txff_write,
    input  logic                    i_txff_full,
    output logic                    o_busy,
    output logic [15:0]             o_frame_count
);

    localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);
    localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT_CYCLES - 1);

    generate
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_data
            $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
        if (OPCODE_WIDTH > BYTE_WIDTH) begin : g_bad_opcode
            $error("OPCODE_WIDTH must not exceed BYTE_WIDTH");
        end
        if (BYTE_WIDTH < 6) begin : g_bad_byte
            $error("BYTE_WIDTH too narrow for the flags byte");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        RX_A,
        RX_B,
        RX_OP,
        EXEC,
        WAIT,
        TX_RES,
        TX_FLAGS
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]           byte_cnt;
    logic [TW-1:0]           wait_cnt;
    logic [DATA_WIDTH-1:0]   operand_a;
    logic [DATA_WIDTH-1:0]   operand_b;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [DATA_WIDTH-1:0]   result;
    logic [4:0]              flags;
    logic                    timeout_bit;
    logic [15:0]             frame_count;

    logic                    rx_pop;
    logic                    tx_push;
    logic                    alu_start;
    logic [BYTE_WIDTH-1:0]   tx_byte;
    logic [BYTE_WIDTH-1:0]   res_byte;
    logic [BYTE_WIDTH-1:0]   flags_byte;
    logic                    byte_last;

    assign byte_last  = (byte_cnt == LAST_BYTE);
    assign res_byte   = BYTE_WIDTH'(result >> (byte_cnt * BYTE_WIDTH));
    assign flags_byte = BYTE_WIDTH'({timeout_bit, flags});

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= RX_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RX_A: begin
                if (rx_pop && byte_last) state_next = RX_B;
            end
            RX_B: begin
                if (rx_pop && byte_last) state_next = RX_OP;
            end
            RX_OP: begin
                if (rx_pop) state_next = EXEC;
            end
            EXEC: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (i_alu_done || wait_cnt == LAST_WAIT) state_next = TX_RES;
            end
            TX_RES: begin
                if (tx_push && byte_last) begin
                    state_next = (SEND_FLAGS != 0) ? TX_FLAGS : RX_A;
                end
            end
            TX_FLAGS: begin
                if (tx_push) state_next = RX_A;
            end
            default: state_next = RX_A;
        endcase
    end

    always_comb begin
        rx_pop    = 1'b0;
        tx_push   = 1'b0;
        alu_start = 1'b0;
        tx_byte   = '0;
        unique case (state)
            RX_A, RX_B, RX_OP: begin
                rx_pop = ~i_rxff_empty;
            end
            EXEC: begin
                alu_start = 1'b1;
            end
            TX_RES: begin
                tx_byte = res_byte;
                tx_push = ~i_txff_full;
            end
            TX_FLAGS: begin
                tx_byte = flags_byte;
                tx_push = ~i_txff_full;
            end
            default: ;
        endcase
        // Handshakes must read as idle for the whole time reset is held.
        if (!i_reset) begin
            rx_pop    = 1'b0;
            tx_push   = 1'b0;
            alu_start = 1'b0;
            tx_byte   = '0;
        end
    end

    // Bytes shift in from the top so the first byte lands in the LSBs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            byte_cnt    <= '0;
            wait_cnt    <= '0;
            operand_a   <= '0;
            operand_b   <= '0;
            opcode      <= '0;
            result      <= '0;
            flags       <= '0;
            timeout_bit <= 1'b0;
            frame_count <= '0;
        end else begin
            unique case (state)
                RX_A: begin
                    if (rx_pop) begin
                        operand_a <= DATA_WIDTH'({i_rx_data, operand_a} >> BYTE_WIDTH);
                        byte_cnt  <= byte_last ? '0 : byte_cnt + 1'b1;
                    end
                end
                RX_B: begin
                    if (rx_pop) begin
                        operand_b <= DATA_WIDTH'({i_rx_data, operand_b} >> BYTE_WIDTH);
                        byte_cnt  <= byte_last ? '0 : byte_cnt + 1'b1;
                    end
                end
                RX_OP: begin
                    if (rx_pop) opcode <= i_rx_data[OPCODE_WIDTH-1:0];
                end
                EXEC: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (i_alu_done) begin
                        result      <= i_alu_result;
                        flags       <= i_alu_flags;
                        timeout_bit <= 1'b0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        result      <= '0;
                        flags       <= '0;
                        timeout_bit <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                TX_RES: begin
                    if (tx_push) begin
                        byte_cnt <= byte_last ? '0 : byte_cnt + 1'b1;
                        if (byte_last && SEND_FLAGS == 0) begin
                            frame_count <= frame_count + 1'b1;
                        end
                    end
                end
                TX_FLAGS: begin
                    if (tx_push) frame_count <= frame_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_rxff_read   = rx_pop;
    assign o_txff_write  = tx_push;
    assign o_alu_start   = alu_start;
    assign o_tx_data     = tx_byte;
    assign o_operandA    = operand_a;
    assign o_operandB    = operand_b;
    assign o_opcode      = opcode;
    assign o_frame_count = frame_count;
    assign o_busy        = !(state == RX_A && byte_cnt == '0);

endmodule
